// File: rtl/ar_grant_arbiter.sv
// Round-robin owner arbiter for the shared CU config/data-return channel.
// Registers the owner's write channel; steers CU responses to the owner.
module ar_grant_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int FIFO_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_grant_req,
    output logic [NUM_REQ-1:0]            ar_grant,
    input  logic [NUM_REQ-1:0]            req_wr_req,
    input  logic [NUM_REQ-1:0]            req_addr_vld,
    input  logic [NUM_REQ-1:0]            req_data_out_vld,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_out,
    input  logic [NUM_REQ-1:0]            req_write_interrupt,
    output logic [NUM_REQ-1:0]            ar_ack,
    output logic [NUM_REQ-1:0]            ar_data_in_vld,
    output logic [NUM_REQ-1:0]            ar_ack_data_done,
    output logic                          ar2cu_wr_req,
    output logic                          ar2cu_addr_vld,
    output logic                          ar2cu_data_out_vld,
    output logic [FIFO_WIDTH-1:0]         ar2cu_addr,
    output logic [DATA_WIDTH-1:0]         ar2cu_data_out,
    output logic                          ar2cu_write_interrupt,
    input  logic                          cu2ar_ack,
    input  logic                          cu2ar_data_in_vld,
    input  logic                          cu2ar_ack_data_done,
    output logic                          ar_busy,
    output logic [2:0]                    ar_owner,
    output logic                          ar_err_unsol
);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              rr_q, rr_d;
    logic [NUM_REQ-1:0]      grant_d;
    logic [2:0]              owner_d;
    logic                    busy_d, err_d;
    logic                    wr_d, av_d, dv_d, wi_d;
    logic [FIFO_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_d;

    logic [2*NUM_REQ-1:0]    dbl_req, dbl_oh;
    logic [NUM_REQ-1:0]      rot_req, rot_oh, pick_oh;
    logic                    pick_vld;
    logic [3:0]              pick_sum;
    logic [2:0]              pick_idx;
    logic [2:0]              rr_next;

    logic                    own_req, own_wr, own_av, own_dv, own_wi;
    logic [FIFO_WIDTH-1:0]   own_addr;
    logic [DATA_WIDTH-1:0]   own_data;
    logic                    unsol;

    // Rotate requests so bit 0 is rr_q, take first set bit, rotate back.
    assign dbl_req = {req_grant_req, req_grant_req} >> rr_q;
    assign rot_req = dbl_req[NUM_REQ-1:0];

    always_comb begin
        rot_oh   = '0;
        pick_vld = 1'b0;
        pick_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && rot_req[i]) begin
                pick_vld  = 1'b1;
                rot_oh[i] = 1'b1;
                pick_sum  = {1'b0, rr_q} + 4'(i);
            end
        end
    end

    assign dbl_oh   = {rot_oh, rot_oh} << rr_q;
    assign pick_oh  = dbl_oh[2*NUM_REQ-1:NUM_REQ];
    assign pick_idx = (pick_sum >= 4'(NUM_REQ)) ?
                      3'(pick_sum - 4'(NUM_REQ)) : pick_sum[2:0];
    assign rr_next  = (ar_owner == 3'(NUM_REQ - 1)) ?
                      3'd0 : ar_owner + 3'd1;

    assign own_req = |(req_grant_req & ar_grant);
    assign own_wr  = |(req_wr_req & ar_grant);
    assign own_av  = |(req_addr_vld & ar_grant);
    assign own_dv  = |(req_data_out_vld & ar_grant);
    assign own_wi  = |(req_write_interrupt & ar_grant);

    always_comb begin
        own_addr = '0;
        own_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ar_grant[k]) begin
                own_addr |= req_addr[k*FIFO_WIDTH +: FIFO_WIDTH];
                own_data |= req_data_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // With no owner every strobe counts as unsolicited.
    assign unsol = |((req_wr_req | req_addr_vld | req_data_out_vld)
                     & ~ar_grant);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = ar_grant;
        owner_d = ar_owner;
        busy_d  = ar_busy;
        err_d   = ar_err_unsol | unsol;
        wr_d    = 1'b0;
        av_d    = 1'b0;
        dv_d    = 1'b0;
        wi_d    = 1'b0;
        addr_d  = ar2cu_addr;
        data_d  = ar2cu_data_out;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (own_req) begin
                    wr_d = own_wr;
                    av_d = own_av;
                    dv_d = own_dv;
                    wi_d = own_wi;
                    if (own_wr || own_av) addr_d = own_addr;
                    if (own_dv) data_d = own_data;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    rr_d    = rr_next;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q               <= IDLE;
            rr_q                  <= '0;
            ar_grant              <= '0;
            ar_owner              <= '0;
            ar_busy               <= 1'b0;
            ar_err_unsol          <= 1'b0;
            ar2cu_wr_req          <= 1'b0;
            ar2cu_addr_vld        <= 1'b0;
            ar2cu_data_out_vld    <= 1'b0;
            ar2cu_write_interrupt <= 1'b0;
            ar2cu_addr            <= '0;
            ar2cu_data_out        <= '0;
        end else begin
            state_q               <= state_d;
            rr_q                  <= rr_d;
            ar_grant              <= grant_d;
            ar_owner              <= owner_d;
            ar_busy               <= busy_d;
            ar_err_unsol          <= err_d;
            ar2cu_wr_req          <= wr_d;
            ar2cu_addr_vld        <= av_d;
            ar2cu_data_out_vld    <= dv_d;
            ar2cu_write_interrupt <= wi_d;
            ar2cu_addr            <= addr_d;
            ar2cu_data_out        <= data_d;
        end
    end

    assign ar_ack           = {NUM_REQ{cu2ar_ack}} & ar_grant;
    assign ar_data_in_vld   = {NUM_REQ{cu2ar_data_in_vld}} & ar_grant;
    assign ar_ack_data_done = {NUM_REQ{cu2ar_ack_data_done}} & ar_grant;

endmodule

// File: tb/tb_ar_grant_arbiter.sv
// Scoreboard bench for ar_grant_arbiter: grants, muxed writes and
// steered responses are queued by stimulus and checked by monitors.
module tb_ar_grant_arbiter;
    localparam int N  = 3;
    localparam int FW = 32;
    localparam int DW = 64;

    typedef struct {
        logic [N-1:0] g;
        logic [2:0]   o;
        int           gap;
    } gexp_t;

    typedef struct {
        logic [3:0]    s;
        logic [FW-1:0] a;
        logic [DW-1:0] d;
    } wexp_t;

    typedef struct {
        logic [N-1:0] ack;
        logic [N-1:0] dv;
        logic [N-1:0] dd;
    } rexp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_grant_req;
    logic [N-1:0]    ar_grant;
    logic [N-1:0]    req_wr_req, req_addr_vld, req_data_out_vld;
    logic [N*FW-1:0] req_addr;
    logic [N*DW-1:0] req_data_out;
    logic [N-1:0]    req_write_interrupt;
    logic [N-1:0]    ar_ack, ar_data_in_vld, ar_ack_data_done;
    logic            ar2cu_wr_req, ar2cu_addr_vld, ar2cu_data_out_vld;
    logic [FW-1:0]   ar2cu_addr;
    logic [DW-1:0]   ar2cu_data_out;
    logic            ar2cu_write_interrupt;
    logic            cu2ar_ack, cu2ar_data_in_vld, cu2ar_ack_data_done;
    logic            ar_busy;
    logic [2:0]      ar_owner;
    logic            ar_err_unsol;

    int    checks = 0;
    int    fails  = 0;
    bit    mon_en = 1'b0;
    gexp_t gq[$];
    wexp_t wq[$];
    rexp_t rq[$];
    logic [N-1:0] prev_g = '0;
    int    zrun = 0;

    always #5 clk = ~clk;

    ar_grant_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(FW), .DATA_WIDTH(DW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_grant_req         (req_grant_req),
        .ar_grant              (ar_grant),
        .req_wr_req            (req_wr_req),
        .req_addr_vld          (req_addr_vld),
        .req_data_out_vld      (req_data_out_vld),
        .req_addr              (req_addr),
        .req_data_out          (req_data_out),
        .req_write_interrupt   (req_write_interrupt),
        .ar_ack                (ar_ack),
        .ar_data_in_vld        (ar_data_in_vld),
        .ar_ack_data_done      (ar_ack_data_done),
        .ar2cu_wr_req          (ar2cu_wr_req),
        .ar2cu_addr_vld        (ar2cu_addr_vld),
        .ar2cu_data_out_vld    (ar2cu_data_out_vld),
        .ar2cu_addr            (ar2cu_addr),
        .ar2cu_data_out        (ar2cu_data_out),
        .ar2cu_write_interrupt (ar2cu_write_interrupt),
        .cu2ar_ack             (cu2ar_ack),
        .cu2ar_data_in_vld     (cu2ar_data_in_vld),
        .cu2ar_ack_data_done   (cu2ar_ack_data_done),
        .ar_busy               (ar_busy),
        .ar_owner              (ar_owner),
        .ar_err_unsol          (ar_err_unsol)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [N-1:0] g, input logic [2:0] o,
                          input int gap);
        gexp_t e;
        e.g = g;
        e.o = o;
        e.gap = gap;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [N-1:0] a, input logic [N-1:0] v,
                          input logic [N-1:0] d);
        rexp_t e;
        e.ack = a;
        e.dv = v;
        e.dd = d;
        rq.push_back(e);
    endtask

    task automatic drive_wr(input int k, input logic [FW-1:0] a,
                            input logic [DW-1:0] d);
        wexp_t e;
        req_wr_req[k]          = 1'b1;
        req_addr_vld[k]        = 1'b1;
        req_data_out_vld[k]    = 1'b1;
        req_addr[k*FW +: FW]     = a;
        req_data_out[k*DW +: DW] = d;
        e.s = 4'b1110;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic clear_wr();
        req_wr_req       = '0;
        req_addr_vld     = '0;
        req_data_out_vld = '0;
    endtask

    task automatic wait_grant(input int k);
        int n;
        n = 0;
        while (!ar_grant[k] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!ar_grant[k]) begin
            fails++;
            $display("FAIL grant_timeout: req %0d got grant %b", k, ar_grant);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        gexp_t ge;
        wexp_t we;
        rexp_t re;
        if (mon_en) begin
            if (ar_grant != prev_g && ar_grant != '0) begin
                if (gq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL grant_unexp: got %b expected none", ar_grant);
                end else begin
                    ge = gq.pop_front();
                    chk("grant", 64'(ar_grant), 64'(ge.g));
                    chk("owner", 64'(ar_owner), 64'(ge.o));
                    chk("busy", 64'(ar_busy), 64'd1);
                    if (ge.gap >= 0) chk("gap", 64'(zrun), 64'(ge.gap));
                end
            end
            zrun   = (ar_grant == '0) ? zrun + 1 : 0;
            prev_g = ar_grant;
            if (ar2cu_wr_req || ar2cu_addr_vld || ar2cu_data_out_vld ||
                ar2cu_write_interrupt) begin
                if (wq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL write_unexp: got addr %0h expected none",
                             ar2cu_addr);
                end else begin
                    we = wq.pop_front();
                    chk("wr_strobes", 64'({ar2cu_wr_req, ar2cu_addr_vld,
                        ar2cu_data_out_vld, ar2cu_write_interrupt}), 64'(we.s));
                    chk("wr_addr", 64'(ar2cu_addr), 64'(we.a));
                    chk("wr_data", ar2cu_data_out, we.d);
                end
            end
            if (|{ar_ack, ar_data_in_vld, ar_ack_data_done}) begin
                if (rq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL resp_unexp: got %b expected none",
                             {ar_ack, ar_data_in_vld, ar_ack_data_done});
                end else begin
                    re = rq.pop_front();
                    chk("ack", 64'(ar_ack), 64'(re.ack));
                    chk("data_in_vld", 64'(ar_data_in_vld), 64'(re.dv));
                    chk("data_done", 64'(ar_ack_data_done), 64'(re.dd));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wexp_t w;
        rst = 1'b0;
        req_grant_req = '0;
        req_addr = '0;
        req_data_out = '0;
        req_write_interrupt = '0;
        cu2ar_ack = 1'b0;
        cu2ar_data_in_vld = 1'b0;
        cu2ar_ack_data_done = 1'b0;
        clear_wr();
        tick();
        tick();
        chk("rst_grant", 64'(ar_grant), 64'd0);
        chk("rst_busy", 64'(ar_busy), 64'd0);
        chk("rst_owner", 64'(ar_owner), 64'd0);
        chk("rst_err", 64'(ar_err_unsol), 64'd0);
        chk("rst_strobes", 64'({ar2cu_wr_req, ar2cu_addr_vld,
            ar2cu_data_out_vld, ar2cu_write_interrupt}), 64'd0);
        chk("rst_addr", 64'(ar2cu_addr), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // single requester
        req_grant_req[0] = 1'b1;
        push_g(3'b001, 3'd0, -1);
        wait_grant(0);
        for (int i = 0; i < 3; i++) begin
            drive_wr(0, 32'h403 + 32'(2 * i), 64'hDA7A_0000_0000_0403 + 64'(2 * i));
            tick();
        end
        clear_wr();
        req_write_interrupt[0] = 1'b1;
        w.s = 4'b0001;
        w.a = 32'h407;
        w.d = 64'hDA7A_0000_0000_0407;
        wq.push_back(w);
        tick();
        req_write_interrupt[0] = 1'b0;
        cu2ar_ack = 1'b1;
        push_r(3'b001, 3'b000, 3'b000);
        tick();
        cu2ar_ack = 1'b0;
        req_grant_req[0] = 1'b0;
        tick();
        chk("rel_grant", 64'(ar_grant), 64'd0);
        chk("rel_busy", 64'(ar_busy), 64'd0);
        repeat (3) tick();

        // contention
        do_reset();
        req_grant_req = 3'b111;
        push_g(3'b001, 3'd0, -1);
        push_g(3'b010, 3'd1, 2);
        push_g(3'b100, 3'd2, 2);
        for (int o = 0; o < N; o++) begin
            wait_grant(o);
            repeat (3) tick();
            req_grant_req[o] = 1'b0;
        end
        repeat (3) tick();

        // fairness
        do_reset();
        req_grant_req = 3'b101;
        push_g(3'b001, 3'd0, -1);
        wait_grant(0);
        repeat (2) tick();
        req_grant_req[0] = 1'b0;
        tick();
        req_grant_req[0] = 1'b1;
        push_g(3'b100, 3'd2, 2);
        push_g(3'b001, 3'd0, 2);
        wait_grant(2);
        repeat (2) tick();
        req_grant_req[2] = 1'b0;
        wait_grant(0);
        tick();
        req_grant_req[0] = 1'b0;
        repeat (3) tick();

        // unsolicited write, write coincident with release
        do_reset();
        req_grant_req[0] = 1'b1;
        push_g(3'b001, 3'd0, -1);
        wait_grant(0);
        req_wr_req[1] = 1'b1;
        tick();
        req_wr_req[1] = 1'b0;
        tick();
        chk("unsol_err", 64'(ar_err_unsol), 64'd1);
        chk("unsol_wr", 64'(ar2cu_wr_req), 64'd0);
        req_wr_req[0] = 1'b1;
        req_addr[0 +: FW] = 32'h500;
        req_grant_req[0] = 1'b0;
        tick();
        clear_wr();
        repeat (3) tick();
        chk("err_sticky", 64'(ar_err_unsol), 64'd1);
        chk("drop_addr", 64'(ar2cu_addr), 64'd0);
        rst = 1'b0;
        tick();
        chk("err_clear", 64'(ar_err_unsol), 64'd0);
        rst = 1'b1;

        // response steering
        req_grant_req[2] = 1'b1;
        push_g(3'b100, 3'd2, -1);
        wait_grant(2);
        cu2ar_data_in_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_r(3'b000, 3'b100, 3'b000);
            tick();
        end
        cu2ar_data_in_vld = 1'b0;
        cu2ar_ack_data_done = 1'b1;
        push_r(3'b000, 3'b000, 3'b100);
        tick();
        cu2ar_ack_data_done = 1'b0;
        req_grant_req[2] = 1'b0;
        cu2ar_ack = 1'b1;
        push_r(3'b100, 3'b000, 3'b000);
        tick();
        cu2ar_ack = 1'b0;
        repeat (3) tick();
        cu2ar_ack = 1'b1;
        cu2ar_data_in_vld = 1'b1;
        cu2ar_ack_data_done = 1'b1;
        @(negedge clk);
        chk("idle_resp", 64'({ar_ack, ar_data_in_vld, ar_ack_data_done}), 64'd0);
        tick();
        cu2ar_ack = 1'b0;
        cu2ar_data_in_vld = 1'b0;
        cu2ar_ack_data_done = 1'b0;

        // reset mid-ownership; first leave rr_ptr at 2
        do_reset();
        req_grant_req[1] = 1'b1;
        push_g(3'b010, 3'd1, -1);
        wait_grant(1);
        tick();
        req_grant_req[1] = 1'b0;
        repeat (3) tick();
        req_grant_req[1] = 1'b1;
        push_g(3'b010, 3'd1, -1);
        wait_grant(1);
        drive_wr(1, 32'h600, 64'hBEEF_0000_0000_0600);
        tick();
        clear_wr();
        rst = 1'b0;
        req_grant_req[2] = 1'b1;
        tick();
        chk("mid_grant", 64'(ar_grant), 64'd0);
        chk("mid_busy", 64'(ar_busy), 64'd0);
        chk("mid_owner", 64'(ar_owner), 64'd0);
        chk("mid_strobes", 64'({ar2cu_wr_req, ar2cu_addr_vld,
            ar2cu_data_out_vld, ar2cu_write_interrupt}), 64'd0);
        chk("mid_addr", 64'(ar2cu_addr), 64'd0);
        chk("mid_data", ar2cu_data_out, 64'd0);
        rst = 1'b1;
        push_g(3'b010, 3'd1, -1);
        push_g(3'b100, 3'd2, 2);
        wait_grant(1);
        repeat (2) tick();
        req_grant_req[1] = 1'b0;
        wait_grant(2);
        tick();
        req_grant_req[2] = 1'b0;
        repeat (3) tick();

        chk("grant_q_left", 64'(gq.size()), 64'd0);
        chk("write_q_left", 64'(wq.size()), 64'd0);
        chk("resp_q_left", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
